bc_datapath: RTL and testbench
==============================

Name: bc_datapath

Overview:
- Operative (datapath) stage driven directly by the sequencing control block.
- Consumes that block's load enables (lx, ls, lh), ALU op (h), operand/source selects (m0, m1, m2) and done.
- Holds working registers X, S and H and a shared add/multiply ALU.
- Latches the final S value as the result, with a sticky valid flag and a sticky overflow flag.

Parameters:
- WIDTH, 16: width of data registers, ALU and result.
- COEF_A, 16'd3: constant operand, selectable on ALU port B.
- COEF_B, 16'd2: constant write source for S.
- COEF_C, 16'd1: constant write source for S.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- x_in  in  WIDTH  operand sampled into X.
- lx  in  1  load X from x_in.
- ls  in  1  load S from the m2 mux.
- lh  in  1  load H from the ALU output.
- h  in  1  ALU op: 1 = multiply, 0 = add.
- m0  in  2  ALU A select: 0 X, 1 S, 2 H, 3 constant 0.
- m1  in  2  ALU B select: 0 X, 1 S, 2 H, 3 COEF_A.
- m2  in  2  S write source: 0 ALU out, 1 x_in, 2 COEF_B, 3 COEF_C.
- done  in  1  capture S into the result register.
- result  out  WIDTH  captured result.
- result_valid  out  1  high from the cycle after done until cleared.
- ovf  out  1  sticky overflow of any committed ALU write.

Behaviour:
- Reset:
  - rst high at a clock edge sets X, S, H, result to 0 and result_valid, ovf to 0.
  - rst dominates every other input in that cycle.
  - Reset mid-computation aborts it with no partial result.
- ALU:
  - Purely combinational: alu = A + B when h=0, A * B when h=1.
  - Result is truncated to WIDTH (mod 2^WIDTH), unsigned.
  - alu_ovf = carry-out for add, or any nonzero product bit at or above WIDTH for multiply.
- Registers (one-cycle latency; new values visible the cycle after the enable):
  - X <= x_in when lx.
  - H <= alu when lh.
  - S <= m2 mux output when ls.
- Simultaneous events:
  - All enables are independent and may assert in the same cycle.
  - Every register samples pre-edge values. Example: lx and ls with m0=0 use the old X.
  - ls and lh together commit the same ALU result into both S and H.
- ovf:
  - Set when (lh) or (ls and m2=0) with alu_ovf=1.
  - Cleared when lx=1 (start of a new operand).
  - A set and a clear in the same cycle leave ovf = 1.
- done:
  - result <= S (pre-edge value) and result_valid <= 1.
  - result holds until the next done or rst.
  - result_valid clears on lx without done. done wins if both assert in one cycle.
- Unused select codes do not exist: all 2-bit codes are defined above.
- No handshake back to control: control owns sequencing. The datapath never stalls.

Decomposition:
- Shared package bc_pkg holds:
  - select localparams: SEL_X=0, SEL_S=1, SEL_H=2, SEL_K=3;
  - S-source codes: SRC_ALU=0, SRC_IN=1, SRC_CB=2, SRC_CC=3;
  - ALU op codes: OP_ADD=0, OP_MUL=1;
  - default WIDTH.
- One sub-module, bc_alu: combinational add/multiply with truncation and overflow output, parameterised by WIDTH.
- Muxes and registers stay in bc_datapath.

Test Plan:
- Reset: drive any inputs, rst=1 for 1 cycle -> X=S=H=result=0, result_valid=0, ovf=0. Reset overrides a simultaneous lx with x_in=7.
- Square: lx with x_in=5; then lh, h=1, m0=0, m1=0 -> H=25; then ls, m2=0, h=0, m0=2, m1=3 -> S=28; then done -> result=28 and result_valid=1 the next cycle, ovf=0.
- Polynomial 3x^2+2x+1, x=4:
  - H=X*X=16; S=COEF_B=2; H=H*COEF_A=48; S=S*X=8; S=S+H=56; H=COEF_C via ls m2=3 then add -> 57.
  - done -> result=57.
- Overflow: WIDTH=16, x=300, lh with h=1, m0=0, m1=0 -> H=24464 and ovf=1. ovf stays 1 through later non-overflowing ops; the next lx clears it.
- Simultaneous: X=9, then lx with x_in=2 plus ls, m2=0, h=0, m0=0, m1=0 in one cycle -> S=18 (old X), X=2.
- Boundary: done and lx in the same cycle -> result=S, result_valid=1. Add 0xFFFF+1 -> 0 with ovf=1.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared encodings for the bc datapath: operand selects, S write sources, ALU ops.
package bc_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_S = 2'd1;
    localparam logic [1:0] SEL_H = 2'd2;
    localparam logic [1:0] SEL_K = 2'd3;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_IN  = 2'd1;
    localparam logic [1:0] SRC_CB  = 2'd2;
    localparam logic [1:0] SRC_CC  = 2'd3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/bc_alu.sv
// Combinational unsigned add/multiply, truncated to WIDTH, with overflow flag.
module bc_alu
    import bc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             ovf_o
);

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        if (op_i == OP_MUL) begin
            y_o   = prod[WIDTH-1:0];
            ovf_o = |prod[2*WIDTH-1:WIDTH];
        end else begin
            y_o   = sum[WIDTH-1:0];
            ovf_o = sum[WIDTH];
        end
    end

endmodule

// File: rtl/bc_datapath.sv
// Operative stage: X/S/H working registers around a shared ALU, plus the
// captured result with sticky valid and overflow flags.
module bc_datapath
    import bc_pkg::*;
#(
    parameter int unsigned      WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COEF_A = WIDTH'(3),
    parameter logic [WIDTH-1:0] COEF_B = WIDTH'(2),
    parameter logic [WIDTH-1:0] COEF_C = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x_in,
    input  logic             lx,
    input  logic             ls,
    input  logic             lh,
    input  logic             h,
    input  logic [1:0]       m0,
    input  logic [1:0]       m1,
    input  logic [1:0]       m2,
    input  logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             ovf
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_y, s_src;
    logic             alu_ovf;

    always_comb begin
        unique case (m0)
            SEL_X:   alu_a = x_q;
            SEL_S:   alu_a = s_q;
            SEL_H:   alu_a = h_q;
            default: alu_a = '0;
        endcase
        unique case (m1)
            SEL_X:   alu_b = x_q;
            SEL_S:   alu_b = s_q;
            SEL_H:   alu_b = h_q;
            default: alu_b = COEF_A;
        endcase
    end

    bc_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i  (h),
        .a_i   (alu_a),
        .b_i   (alu_b),
        .y_o   (alu_y),
        .ovf_o (alu_ovf)
    );

    always_comb begin
        unique case (m2)
            SRC_ALU: s_src = alu_y;
            SRC_IN:  s_src = x_in;
            SRC_CB:  s_src = COEF_B;
            default: s_src = COEF_C;
        endcase
    end

    always_comb begin
        x_d     = lx ? x_in : x_q;
        h_d     = lh ? alu_y : h_q;
        s_d     = ls ? s_src : s_q;
        res_d   = done ? s_q : res_q;
        valid_d = valid_q;
        if (lx)   valid_d = 1'b0;
        if (done) valid_d = 1'b1;
        // Clear first so a same-cycle overflow commit still leaves the flag set.
        ovf_d = ovf_q;
        if (lx) ovf_d = 1'b0;
        if ((lh || (ls && m2 == SRC_ALU)) && alu_ovf) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            s_q     <= '0;
            h_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            s_q     <= s_d;
            h_q     <= h_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result       = res_q;
    assign result_valid = valid_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_bc_datapath.sv
// Directed-vector bench for bc_datapath; internal registers are observed by
// routing them into S and capturing S with done.
module tb_bc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x_in;
    logic        lx, ls, lh, h, done;
    logic [1:0]  m0, m1, m2;
    logic [15:0] result;
    logic        result_valid, ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bc_datapath dut (
        .clk(clk), .rst(rst), .x_in(x_in),
        .lx(lx), .ls(ls), .lh(lh), .h(h),
        .m0(m0), .m1(m1), .m2(m2), .done(done),
        .result(result), .result_valid(result_valid), .ovf(ovf)
    );

    task automatic idle();
        rst = 0; lx = 0; ls = 0; lh = 0; h = 0; done = 0;
        m0 = 0; m1 = 0; m2 = 0; x_in = 0;
    endtask

    // One clock with the given controls, then return all enables to idle.
    task automatic cyc(input logic ilx, input logic ils, input logic ilh,
                       input logic ih, input logic [1:0] im0, input logic [1:0] im1,
                       input logic [1:0] im2, input logic idone, input logic [15:0] ix);
        lx = ilx; ls = ils; lh = ilh; h = ih; m0 = im0; m1 = im1; m2 = im2;
        done = idone; x_in = ix;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; lx = 1; x_in = 16'd7; ls = 1; m2 = 2'd1; lh = 1; done = 1;
        @(posedge clk); #1;
        idle();
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", result_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        // S = 0 + X must be 0, proving lx was overridden
        cyc(0, 1, 0, 0, 2'd3, 2'd0, 2'd0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_x got %0d want 0", result); end
    endtask

    task automatic test_square();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd5);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL sq_valid_clear got %0b want 0", result_valid); end
        cyc(0, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0);
        cyc(0, 1, 0, 0, 2'd2, 2'd3, 2'd0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd28) begin errors++; $display("FAIL sq_result got %0d want 28", result); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL sq_valid got %0b want 1", result_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sq_ovf got %0b want 0", ovf); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (result !== 16'd28 || result_valid !== 1'b1) begin errors++; $display("FAIL sq_hold got %0d/%0b want 28/1", result, result_valid); end
    endtask

    task automatic test_reset_abort();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd6);
        cyc(0, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0);
        rst = 1; done = 1;
        @(posedge clk); #1;
        idle();
        checks++; if (result !== 16'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL abort got %0d/%0b want 0/0", result, result_valid); end
    endtask

    task automatic test_poly();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd4);
        cyc(0, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0);      // H = 16
        cyc(0, 1, 0, 0, 0, 0, 2'd2, 0, 0);         // S = 2
        cyc(0, 0, 1, 1, 2'd2, 2'd3, 0, 0, 0);      // H = 48
        cyc(0, 1, 0, 1, 2'd1, 2'd0, 2'd0, 0, 0);   // S = 8
        cyc(0, 1, 0, 0, 2'd1, 2'd2, 2'd0, 0, 0);   // S = 56
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd56) begin errors++; $display("FAIL poly_mid got %0d want 56", result); end
        cyc(0, 0, 1, 0, 2'd3, 2'd1, 0, 0, 0);      // H = 56
        cyc(0, 1, 0, 0, 0, 0, 2'd3, 0, 0);         // S = 1
        cyc(0, 1, 0, 0, 2'd1, 2'd2, 2'd0, 0, 0);   // S = 57
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd57) begin errors++; $display("FAIL poly got %0d want 57", result); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL poly_ovf got %0b want 0", ovf); end
    endtask

    task automatic test_overflow();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd300);
        // S load from x_in with an overflowing ALU must not set ovf
        cyc(0, 1, 0, 1, 2'd0, 2'd0, 2'd1, 0, 16'd11);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_nonalu got %0b want 0", ovf); end
        cyc(0, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0);      // H = 90000 mod 65536
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_mul got %0b want 1", ovf); end
        cyc(0, 1, 0, 0, 2'd3, 2'd2, 2'd0, 0, 0);   // S = 0 + H
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd24464) begin errors++; $display("FAIL ovf_h got %0d want 24464", result); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", ovf); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", ovf); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid_clear got %0b want 0", result_valid); end
    endtask

    task automatic test_back_to_back();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd9);
        // lx with ls/lh: both use old X = 9 -> S = H = 18, X = 2
        cyc(1, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0, 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd18) begin errors++; $display("FAIL simul_s got %0d want 18", result); end
        cyc(0, 1, 0, 0, 2'd2, 2'd0, 2'd0, 0, 0);   // S = H + X = 20
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd20) begin errors++; $display("FAIL simul_hx got %0d want 20", result); end
        // done and lx together: result = S, valid stays set
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'd3);
        checks++; if (result !== 16'd20 || result_valid !== 1'b1) begin errors++; $display("FAIL done_lx got %0d/%0b want 20/1", result, result_valid); end
    endtask

    task automatic test_boundary();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        cyc(0, 1, 0, 0, 0, 0, 2'd3, 0, 0);         // S = 1
        cyc(0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 0, 0);   // S = FFFF + 1
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf got %0b want 1", ovf); end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL add_wrap got %0d want 0", result); end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd300);
        // clear and set in the same cycle leave ovf high
        cyc(1, 0, 1, 1, 2'd0, 2'd0, 0, 0, 16'd5);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_setclr got %0b want 1", ovf); end
        cyc(0, 1, 0, 0, 2'd3, 2'd0, 2'd0, 0, 0);   // S = 0 + X = 5
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (result !== 16'd5) begin errors++; $display("FAIL setclr_x got %0d want 5", result); end
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_square();
        test_reset_abort();
        test_poly();
        test_overflow();
        test_back_to_back();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
